mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single AXI-lite-style memory port (AR/R/AW/W/B channels, RESP_WDTH-bit responses, resp=1 meaning OK) between the insertion-sort controller and a host-side loader/checker. Each requester issues one word-sized read or write through a simple req/ack command interface. The arbiter serialises whole transactions with round-robin priority and runs the channel handshakes. It sits between the requesters and the memory model/interconnect.

## Interface
- ADDR_WDTH, 4, word address width
- DATA_WDTH, 32, data width
- RESP_WDTH, 1, response width; value 1 = OK, 0 = error
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  requester N command request; level, held until ackN
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN high
- addr0 / addr1  in  ADDR_WDTH  command address
- wdata0 / wdata1  in  DATA_WDTH  write data
- ack0 / ack1  out  1  one-cycle completion pulse to requester N
- rdata  out  DATA_WDTH  read data; valid when ack0|ack1 on a read
- resp  out  RESP_WDTH  transaction response; valid when ack0|ack1
- owner  out  1  index of the requester currently granted
- busy  out  1  high in every state except IDLE
- ar_valid  out  1 / ar_ready  in  1 / ar_addr  out  ADDR_WDTH
- r_valid  in  1 / r_ready  out  1 / r_data  in  DATA_WDTH / r_resp  in  RESP_WDTH
- aw_valid  out  1 / aw_ready  in  1 / aw_addr  out  ADDR_WDTH
- w_valid  out  1 / w_ready  in  1 / w_data  out  DATA_WDTH
- b_valid  in  1 / b_ready  out  1 / b_resp  in  RESP_WDTH

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, COMPLETE. An illegal encoding goes to IDLE.
- IDLE: reqN is sampled only here. If exactly one request is high, grant it. If both are high, grant the requester other than last_grant. At grant, latch owner, we, addr and wdata. Go to RD_ADDR if we=0, else WR_ADDR_DATA.
- last_grant updates at each grant. Its reset value is 1, so requester 0 wins the first tie.
- RD_ADDR: ar_valid=1 with ar_addr=latched addr. Leave for RD_DATA at the edge where ar_ready=1.
- RD_DATA: r_ready=1. At the edge where r_valid=1, capture r_data into rdata and r_resp into resp, then go to COMPLETE.
- WR_ADDR_DATA: aw_valid stays high until aw_ready is seen; w_valid stays high until w_ready is seen. Two flags, aw_done and w_done, track each channel independently. Each valid drops the cycle after its own ready. Both readies in the same cycle is legal. Go to WR_RESP when both are done; clear the flags on exit.
- WR_RESP: b_ready=1. At the edge where b_valid=1, capture b_resp into resp and go to COMPLETE. rdata keeps its previous value.
- COMPLETE: ack[owner]=1 for exactly one cycle, then go to IDLE.
- The requester deasserts req on the edge where it samples ack=1. A req still high in the following IDLE cycle is treated as a new request.
- An error response (resp=0) is passed through to the requester. The arbiter itself has no error state.
- VALID signals and their addr/data stay stable until the matching READY. No valid is ever withdrawn.

## Timing
- Reset (asynchronous) applies immediately: state=IDLE; ar_valid, aw_valid, w_valid, r_ready, b_ready, ack0, ack1, busy = 0; owner=0; rdata=0; resp=0; ar_addr, aw_addr, w_data = 0; last_grant=1; aw_done=w_done=0.
- Reset mid-transaction abandons the transaction and issues no ack. The memory side is reset by the same rst_n.
- Grant latency: req high in an IDLE cycle leads to the channel valid in the next cycle.
- Minimum read, with ready/valid already high: req at cycle 0, ar_valid at 1, r_ready at 2, ack at 3. Each wait cycle on ar_ready or r_valid adds one cycle.
- Minimum write: req at cycle 0, aw_valid/w_valid at 1, b_ready at 2, ack at 3. Completion waits for the later of aw_ready and w_ready.
- All outputs are registered or decoded from the state register. There is no combinational path from memory inputs to memory outputs.
- Back-to-back throughput is one transaction per 4 cycles minimum.

## Test plan
- Single read: req0=1, we0=0, addr0=4'h3; memory has ar_ready=1, then r_valid=1, r_data=32'hDEADBEEF, r_resp=1. Expect ar_addr=3 at cycle 1, ack0 at cycle 3 with rdata=DEADBEEF and resp=1; ack1 stays 0.
- Write with skewed readies: req1=1, we1=1, addr1=4'h7, wdata1=32'h5; aw_ready is held off for 3 cycles, w_ready=1 immediately. Expect w_valid for 1 cycle and aw_valid for 4 cycles. Then b_valid=1, b_resp=1 gives ack1 with resp=1.
- Simultaneous requests held continuously: both reqs high. Expect grant order 0,1,0,1 over four transactions; owner matches each ack.
- Error passthrough: a read returns r_resp=0. Expect ack with resp=0, then IDLE, and the next request is serviced normally.
- Reset mid-operation: assert rst_n=0 during RD_DATA. Expect every output at its reset value immediately and no ack. After release, req1 and req0 both high give a grant to requester 0.
- Ready stalls: ar_ready is held low for 10 cycles. Expect ar_valid and ar_addr stable throughout, and busy=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises whole read/write transactions from two
// req/ack requesters onto a single AXI-lite-style memory port.
module mem_port_arbiter #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_WDTH-1:0] addr0,
    input  logic [ADDR_WDTH-1:0] addr1,
    input  logic [DATA_WDTH-1:0] wdata0,
    input  logic [DATA_WDTH-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [DATA_WDTH-1:0] rdata,
    output logic [RESP_WDTH-1:0] resp,
    output logic                 owner,
    output logic                 busy,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_addr,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RD_ADDR      = 3'd1,
        RD_DATA      = 3'd2,
        WR_ADDR_DATA = 3'd3,
        WR_RESP      = 3'd4,
        COMPLETE     = 3'd5
    } state_t;

    state_t                 state;
    logic                   last_grant;
    logic                   aw_done;
    logic                   w_done;
    logic                   gnt;
    logic                   gnt_we;
    logic [ADDR_WDTH-1:0]   gnt_addr;
    logic [DATA_WDTH-1:0]   gnt_wdata;

    // On a tie the requester that did not win last time goes next.
    assign gnt       = (req0 && req1) ? ~last_grant : req1;
    assign gnt_we    = gnt ? we1 : we0;
    assign gnt_addr  = gnt ? addr1 : addr0;
    assign gnt_wdata = gnt ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            resp       <= '0;
            owner      <= 1'b0;
            busy       <= 1'b0;
            ar_valid   <= 1'b0;
            ar_addr    <= '0;
            r_ready    <= 1'b0;
            aw_valid   <= 1'b0;
            aw_addr    <= '0;
            w_valid    <= 1'b0;
            w_data     <= '0;
            b_ready    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= gnt;
                        last_grant <= gnt;
                        busy       <= 1'b1;
                        if (gnt_we) begin
                            state    <= WR_ADDR_DATA;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            aw_addr  <= gnt_addr;
                            w_data   <= gnt_wdata;
                        end else begin
                            state    <= RD_ADDR;
                            ar_valid <= 1'b1;
                            ar_addr  <= gnt_addr;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_valid) begin
                        r_ready <= 1'b0;
                        rdata   <= r_data;
                        resp    <= r_resp;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        state   <= COMPLETE;
                    end
                end
                WR_ADDR_DATA: begin
                    // Address and data channels complete independently, in either order.
                    if (!aw_done && aw_ready) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (!w_done && w_ready) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if ((aw_done || aw_ready) && (w_done || w_ready)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        b_ready <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_valid) begin
                        b_ready <= 1'b0;
                        resp    <= b_resp;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        state   <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ar_valid <= 1'b0;
                    r_ready  <= 1'b0;
                    aw_valid <= 1'b0;
                    w_valid  <= 1'b0;
                    b_ready  <= 1'b0;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queued requesters, a memory responder with
// programmable ready/valid delays, and a latency-arithmetic reference model.
module tb_mem_port_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int RW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, owner, busy;
    logic [DW-1:0] rdata;
    logic [RW-1:0] resp;
    logic          ar_valid, ar_ready = 0;
    logic [AW-1:0] ar_addr;
    logic          r_valid = 0, r_ready;
    logic [DW-1:0] r_data = '0;
    logic [RW-1:0] r_resp = '0;
    logic          aw_valid, aw_ready = 0;
    logic [AW-1:0] aw_addr;
    logic          w_valid, w_ready = 0;
    logic [DW-1:0] w_data;
    logic          b_valid = 0, b_ready;
    logic [RW-1:0] b_resp = '0;

    mem_port_arbiter #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .resp(resp),
        .owner(owner), .busy(busy),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t q0[$];
    cmd_t q1[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // responder configuration, changed only while the port is idle
    int   ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic rd_resp_cfg = 1'b1, b_resp_cfg = 1'b1;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] mmem [16];

    int      ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit      pend_r, pend_b, aw_seen, w_seen;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    // reference model: one transaction in flight, timing from delay arithmetic
    int      idle_from, g, t_ack, t_ar, t_r, t_aw, t_w, t_b;
    bit      t_live;
    logic    t_we, t_who, last, exp_owner, t_resp, exp_resp;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata, exp_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic reset_side();
        idle_from = 0; t_live = 0; last = 1'b1;
        exp_owner = 1'b0; exp_rdata = '0; exp_resp = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        pend_r = 0; pend_b = 0; aw_seen = 0; w_seen = 0;
        q0.delete(); q1.delete();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    endtask

    task automatic step();
        logic e_arv, e_rr, e_awv, e_wv, e_br, e_a0, e_a1, who;
        int ws;
        if (!rst_n) begin
            reset_side();
            chk("rst_ack", {ack1, ack0}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_owner", owner, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_resp", resp, 0);
            chk("rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready}, 0);
            chk("rst_addr_data", {ar_addr, aw_addr, w_data}, 0);
            return;
        end
        // expected outputs for this cycle
        if (t_live && cyc == t_ack) begin
            exp_resp = t_resp;
            if (!t_we) exp_rdata = t_rdata;
        end
        ws    = g + 2 + imax(t_aw, t_w);
        e_a0  = t_live && cyc == t_ack && !t_who;
        e_a1  = t_live && cyc == t_ack && t_who;
        e_arv = t_live && !t_we && cyc >= g + 1 && cyc <= g + 1 + t_ar;
        e_rr  = t_live && !t_we && cyc >= g + 2 + t_ar && cyc < t_ack;
        e_awv = t_live && t_we && cyc >= g + 1 && cyc <= g + 1 + t_aw;
        e_wv  = t_live && t_we && cyc >= g + 1 && cyc <= g + 1 + t_w;
        e_br  = t_live && t_we && cyc >= ws && cyc < t_ack;
        chk("ack0", ack0, e_a0);
        chk("ack1", ack1, e_a1);
        chk("busy", busy, cyc < idle_from);
        chk("owner", owner, exp_owner);
        chk("rdata", rdata, exp_rdata);
        chk("resp", resp, exp_resp);
        chk("ar_valid", ar_valid, e_arv);
        chk("r_ready", r_ready, e_rr);
        chk("aw_valid", aw_valid, e_awv);
        chk("w_valid", w_valid, e_wv);
        chk("b_ready", b_ready, e_br);
        if (e_arv) chk("ar_addr", ar_addr, t_addr);
        if (e_awv) chk("aw_addr", aw_addr, t_addr);
        if (e_wv)  chk("w_data", w_data, t_wdata);

        // requesters drop a command on its ack
        if (ack0 && q0.size() != 0) void'(q0.pop_front());
        if (ack1 && q1.size() != 0) void'(q1.pop_front());
        if (q0.size() != 0) begin req0 = 1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        else begin req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; end
        if (q1.size() != 0) begin req1 = 1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
        else begin req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; end

        // memory responder
        r_valid = pend_r && r_cnt == r_wait;
        r_data  = r_valid ? mem[rd_addr] : '0;
        r_resp  = rd_resp_cfg;
        if (pend_r && !r_valid) r_cnt++;
        if (r_valid && r_ready) begin pend_r = 0; r_cnt = 0; end
        ar_ready = ar_valid && ar_cnt == ar_wait;
        if (ar_valid && !ar_ready) ar_cnt++;
        if (ar_ready) begin ar_cnt = 0; rd_addr = ar_addr; pend_r = 1; end

        b_valid = pend_b && b_cnt == b_wait;
        b_resp  = b_resp_cfg;
        if (pend_b && !b_valid) b_cnt++;
        if (b_valid && b_ready) begin pend_b = 0; b_cnt = 0; end
        aw_ready = aw_valid && aw_cnt == aw_wait;
        if (aw_valid && !aw_ready) aw_cnt++;
        if (aw_ready) begin aw_cnt = 0; aw_seen = 1; wr_addr = aw_addr; end
        w_ready = w_valid && w_cnt == w_wait;
        if (w_valid && !w_ready) w_cnt++;
        if (w_ready) begin w_cnt = 0; w_seen = 1; wr_data = w_data; end
        if (aw_seen && w_seen) begin mem[wr_addr] = wr_data; pend_b = 1; aw_seen = 0; w_seen = 0; end

        // model grant decision for this idle cycle
        if (cyc >= idle_from && (req0 || req1)) begin
            who = (req0 && req1) ? !last : req1;
            last = who; exp_owner = who; t_who = who;
            g = cyc; t_live = 1;
            t_we = who ? we1 : we0;
            t_addr = who ? addr1 : addr0;
            t_wdata = who ? wdata1 : wdata0;
            t_ar = ar_wait; t_r = r_wait; t_aw = aw_wait; t_w = w_wait; t_b = b_wait;
            if (!t_we) begin
                t_rdata = mmem[t_addr]; t_resp = rd_resp_cfg;
                t_ack = g + 3 + t_ar + t_r;
            end else begin
                mmem[t_addr] = t_wdata; t_resp = b_resp_cfg;
                t_ack = g + 3 + imax(t_aw, t_w) + t_b;
            end
            idle_from = t_ack + 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            step();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic wait_ack(input int budget, output int who);
        who = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ack0 || ack1) begin who = ack1 ? 1 : 0; return; end
        end
        vectors++; miscompares++;
        $display("FAIL ack_timeout: no ack in %0d cycles, required one", budget);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (q0.size() == 0 && q1.size() == 0 && cyc >= idle_from) return;
        end
        vectors++; miscompares++;
        $display("FAIL idle_timeout: port not idle in %0d cycles", budget);
    endtask

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        return c;
    endfunction

    initial begin
        int who;
        int n_aw, n_w;
        bit seen_ack;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'h1000_0000 + i;
            mmem[i] = 32'h1000_0000 + i;
        end
        mem[3] = 32'hDEAD_BEEF; mmem[3] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // single read, zero wait states
        #1 q0.push_back(mk(0, 4'h3, '0));
        @(negedge clk); #1;
        chk("t1_req0_c0", req0, 1);
        chk("t1_arv_c0", ar_valid, 0);
        @(negedge clk); #1;
        chk("t1_arv_c1", ar_valid, 1);
        chk("t1_araddr_c1", ar_addr, 4'h3);
        @(negedge clk); #1;
        chk("t1_rready_c2", r_ready, 1);
        @(negedge clk); #1;
        chk("t1_ack0_c3", ack0, 1);
        chk("t1_ack1_c3", ack1, 0);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_resp", resp, 1);
        wait_idle(20);

        // write with aw_ready held off three cycles
        aw_wait = 3; w_wait = 0; b_wait = 0;
        @(posedge clk); #1 q1.push_back(mk(1, 4'h7, 32'h5));
        n_aw = 0; n_w = 0; seen_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (aw_valid) n_aw++;
            if (w_valid) n_w++;
            if (ack1) begin seen_ack = 1; chk("t2_resp", resp, 1); end
        end
        chk("t2_aw_cycles", n_aw, 4);
        chk("t2_w_cycles", n_w, 1);
        chk("t2_ack1_seen", seen_ack, 1);
        wait_idle(20);

        // both requesters busy: strict alternation starting at 0
        ar_wait = 1; r_wait = 2; aw_wait = 0; w_wait = 2; b_wait = 1;
        @(posedge clk); #1;
        q0.push_back(mk(0, 4'h7, '0));
        q0.push_back(mk(1, 4'h2, 32'hAA));
        q1.push_back(mk(0, 4'h3, '0));
        q1.push_back(mk(0, 4'h2, '0));
        wait_ack(30, who); chk("t3_order0", who, 0); chk("t3_owner0", owner, 0);
        chk("t3_rd7", rdata, 32'h5);
        wait_ack(30, who); chk("t3_order1", who, 1); chk("t3_owner1", owner, 1);
        chk("t3_rd3", rdata, 32'hDEAD_BEEF);
        wait_ack(30, who); chk("t3_order2", who, 0); chk("t3_owner2", owner, 0);
        wait_ack(30, who); chk("t3_order3", who, 1); chk("t3_owner3", owner, 1);
        chk("t3_rd2", rdata, 32'hAA);
        wait_idle(20);

        // error response passes through, next transaction is clean
        ar_wait = 0; r_wait = 0; w_wait = 0; b_wait = 0;
        rd_resp_cfg = 0;
        @(posedge clk); #1 q1.push_back(mk(0, 4'h3, '0));
        wait_ack(20, who); chk("t4_err_who", who, 1); chk("t4_err_resp", resp, 0);
        wait_idle(20);
        rd_resp_cfg = 1;
        @(posedge clk); #1 q0.push_back(mk(0, 4'h5, '0));
        wait_ack(20, who); chk("t4_ok_who", who, 0); chk("t4_ok_resp", resp, 1);
        chk("t4_ok_rdata", rdata, 32'h1000_0005);
        wait_idle(20);

        // ar_ready stalled ten cycles
        ar_wait = 10;
        @(posedge clk); #1 q0.push_back(mk(0, 4'h9, '0));
        n_aw = 0; seen_ack = 0;
        for (int i = 0; i < 30 && !seen_ack; i++) begin
            @(negedge clk); #1;
            if (ar_valid) begin
                n_aw++;
                chk("t6_araddr", ar_addr, 4'h9);
                chk("t6_busy", busy, 1);
            end
            if (ack0) seen_ack = 1;
        end
        chk("t6_ar_cycles", n_aw, 11);
        chk("t6_ack", seen_ack, 1);
        wait_idle(20);

        // reset while waiting in RD_DATA
        ar_wait = 0; r_wait = 6;
        @(posedge clk); #1 q0.push_back(mk(0, 4'h1, '0));
        seen_ack = 0;
        for (int i = 0; i < 20 && !seen_ack; i++) begin
            @(negedge clk); #1;
            if (r_ready) seen_ack = 1;
        end
        chk("t5_reached_rd_data", seen_ack, 1);
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("t5_async_ack", {ack1, ack0}, 0);
        chk("t5_async_rready", r_ready, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_out", {rdata, resp, owner}, 0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("t5_no_ack", {ack1, ack0}, 0);
        end
        r_wait = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        q1.push_back(mk(0, 4'h4, '0));
        q0.push_back(mk(0, 4'h6, '0));
        wait_ack(20, who); chk("t5_first_grant", who, 0);
        chk("t5_rdata", rdata, 32'h1000_0006);
        wait_ack(20, who); chk("t5_second_grant", who, 1);
        chk("t5_rdata2", rdata, 32'h1000_0004);
        wait_idle(20);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
